// File: rtl/weight_stream_loader_if.sv
// FIFO read port and PE-array stream of the weight stream loader.
// master = loader side, slave = FIFO/PE-array side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

interface weight_stream_loader_if;
    logic [`DATA_WIDTH-1:0] i_weight_in;
    logic                   i_weight_ready;
    logic                   o_weight_valid;
    logic [`DATA_WIDTH-1:0] o_pe_weight;
    logic                   o_pe_weight_valid;
    logic                   o_pe_weight_last;
    logic                   i_pe_ready;

    modport master (
        input  i_weight_in, i_weight_ready, i_pe_ready,
        output o_weight_valid, o_pe_weight, o_pe_weight_valid, o_pe_weight_last
    );
    modport slave (
        output i_weight_in, i_weight_ready, i_pe_ready,
        input  o_weight_valid, o_pe_weight, o_pe_weight_valid, o_pe_weight_last
    );
endinterface

// File: rtl/weight_stream_loader.sv
// Streams one weight pass from the weight FIFO to the PE array in chunked reads.
// Optional checksum output enabled by WEIGHT_LOADER_CHECKSUM_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module weight_stream_loader #(
    parameter int CNT_WIDTH = 20,
    parameter int CHUNK_LEN = 32
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_total_words,
    output logic                 o_load_w_finish,
    output logic                 o_busy,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [31:0]          o_checksum,
`endif
    weight_stream_loader_if.master wb
);
    localparam int DW = `DATA_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] total, issued, delivered, remain, delivered_nxt;
    logic [6:0]           chunk_len, chunk_cnt;
    logic [DW-1:0]        mem [4];
    logic [DW-1:0]        head;
    logic [1:0]           wr_ptr, rd_ptr;
    logic [2:0]           occ;
    logic                 inflight;
    logic                 rd_en, push, pop, pe_vld, chunk_end;

    assign remain        = total - issued;
    // Keeping occ + inflight <= 2 before a read bounds the 4-entry queue.
    assign rd_en         = (state == S_BURST) && (chunk_cnt < chunk_len) &&
                           ((occ + {2'b0, inflight}) <= 3'd2);
    assign chunk_end     = rd_en && (chunk_cnt == chunk_len - 7'd1);
    assign push          = inflight;
    assign pe_vld        = (occ != 3'd0);
    assign pop           = pe_vld && wb.i_pe_ready;
    assign delivered_nxt = delivered + CNT_WIDTH'(pop);
    assign head          = mem[rd_ptr];

    assign wb.o_weight_valid    = rd_en;
    assign wb.o_pe_weight_valid = pe_vld;
    assign wb.o_pe_weight       = pe_vld ? head : '0;
    assign wb.o_pe_weight_last  = pe_vld && (delivered == total - CNT_WIDTH'(1));
    assign o_busy               = (state != S_IDLE);

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state           <= S_IDLE;
            total           <= '0;
            issued          <= '0;
            delivered       <= '0;
            chunk_len       <= '0;
            chunk_cnt       <= '0;
            inflight        <= 1'b0;
            o_load_w_finish <= 1'b0;
        end else begin
            o_load_w_finish <= (state == S_DONE);
            inflight        <= rd_en;
            if (rd_en) begin
                chunk_cnt <= chunk_cnt + 7'd1;
                issued    <= issued + CNT_WIDTH'(1);
            end
            if (pop) delivered <= delivered_nxt;
            case (state)
                S_IDLE: if (i_start) begin
                    total <= i_total_words;
                    state <= (i_total_words == '0) ? S_DONE : S_WAIT;
                end
                S_WAIT: if (wb.i_weight_ready) begin
                    state     <= S_BURST;
                    chunk_cnt <= '0;
                    chunk_len <= (remain < CNT_WIDTH'(CHUNK_LEN)) ? 7'(remain) : 7'(CHUNK_LEN);
                end
                S_BURST: if (chunk_end)
                    state <= (issued + CNT_WIDTH'(1) == total) ? S_DRAIN : S_WAIT;
                // Finish is registered off DONE, so leave DRAIN on the final pop itself.
                S_DRAIN: if (delivered_nxt == total) state <= S_DONE;
                S_DONE: begin
                    state     <= S_IDLE;
                    total     <= '0;
                    issued    <= '0;
                    delivered <= '0;
                    chunk_len <= '0;
                    chunk_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            occ <= occ + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge s_clk) begin
        if (push) mem[wr_ptr] <= wb.i_weight_in;
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n)
            o_checksum <= '0;
        else if (state == S_IDLE && i_start)
            o_checksum <= '0;
        else if (pop)
            o_checksum <= o_checksum + (head[DW-1:DW-32] ^ head[31:0]);
    end
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader: FIFO read-port model, output monitor, checks.
// Also covers the checksum port when WEIGHT_LOADER_CHECKSUM_EN is defined.
module tb_weight_stream_loader;
    logic        s_clk, s_rst_n, i_start, o_load_w_finish, o_busy;
    logic [19:0] i_total_words;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] o_checksum;
`endif

    weight_stream_loader_if bus();

    weight_stream_loader dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .i_start(i_start), .i_total_words(i_total_words),
        .o_load_w_finish(o_load_w_finish), .o_busy(o_busy),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .wb(bus.master)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int n_reads, n_fin, fin_cyc, first_valid, last_deliv, stall_err, ovf, t0;
    int read_cyc[$];
    int last_idx[$];
    logic [63:0] got[$];
    logic [31:0] src_tag;
    int src_idx;
    logic rv, stalled, held_l;
    logic [63:0] held_w;

    initial begin
        s_clk = 0;
        forever #5 s_clk = ~s_clk;
    end

    initial forever begin
        @(posedge s_clk);
        cyc++;
    end

    // Weight FIFO model: data follows a read enable by one cycle.
    initial forever begin
        @(negedge s_clk);
        rv = bus.o_weight_valid;
        @(posedge s_clk);
        #1;
        if (rv) begin
            bus.i_weight_in = {src_tag, 32'(src_idx)};
            src_idx++;
        end
    end

    initial begin
        stalled = 0;
        forever begin
            @(negedge s_clk);
            if (s_rst_n) begin
                if (bus.o_weight_valid) begin n_reads++; read_cyc.push_back(cyc); end
                if (stalled && (!bus.o_pe_weight_valid || bus.o_pe_weight !== held_w ||
                                bus.o_pe_weight_last !== held_l)) stall_err++;
                stalled = bus.o_pe_weight_valid && !bus.i_pe_ready;
                held_w  = bus.o_pe_weight;
                held_l  = bus.o_pe_weight_last;
                if (bus.o_pe_weight_valid && first_valid < 0) first_valid = cyc;
                if (bus.o_pe_weight_valid && bus.i_pe_ready) begin
                    got.push_back(bus.o_pe_weight);
                    last_deliv = cyc;
                    if (bus.o_pe_weight_last) last_idx.push_back(got.size() - 1);
                end
                if (o_load_w_finish) begin n_fin++; fin_cyc = cyc; end
                if (dut.occ > 3'd4) ovf++;
            end else
                stalled = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input int n, input logic [31:0] tag);
        got.delete(); read_cyc.delete(); last_idx.delete();
        n_reads = 0; n_fin = 0; fin_cyc = -1; first_valid = -1; last_deliv = -1;
        stall_err = 0; ovf = 0; src_idx = 0; src_tag = tag;
        @(posedge s_clk); #1;
        i_start = 1; i_total_words = 20'(n); t0 = cyc;
        @(posedge s_clk); #1;
        i_start = 0; i_total_words = 20'd5;
    endtask

    task automatic wait_fin(input string tag, input int budget, input bit rand_ready);
        for (int i = 0; i < budget && n_fin == 0; i++) begin
            @(posedge s_clk); #1;
            if (rand_ready) bus.i_pe_ready = 1'($urandom_range(0, 1));
        end
        bus.i_pe_ready = 1;
        chk({tag, "_finish_seen"}, 64'(n_fin > 0), 64'd1);
        repeat (4) @(posedge s_clk);
        #1;
    endtask

    task automatic chk_data(input string tag, input int n, input logic [31:0] tag_v);
        int errs = 0;
        chk({tag, "_count"}, 64'(got.size()), 64'(n));
        foreach (got[i]) if (got[i] !== {tag_v, 32'(i)}) errs++;
        chk({tag, "_order"}, 64'(errs), 64'd0);
        chk({tag, "_reads"}, 64'(n_reads), 64'(n));
        chk({tag, "_fin_pulses"}, 64'(n_fin), 64'd1);
        chk({tag, "_last_cnt"}, 64'(last_idx.size()), 64'd1);
        chk({tag, "_last_idx"}, 64'(last_idx.size() > 0 ? last_idx[0] : -1), 64'(n - 1));
        chk({tag, "_fin_after_last"}, 64'(fin_cyc - last_deliv), 64'd2);
    endtask

    function automatic logic [31:0] cks(input logic [31:0] tag_v, input int n);
        logic [31:0] s = 0;
        for (int i = 0; i < n; i++) s = s + (tag_v ^ 32'(i));
        return s;
    endfunction

    initial begin
        s_rst_n = 0; i_start = 0; i_total_words = 0;
        bus.i_weight_in = 0; bus.i_weight_ready = 1; bus.i_pe_ready = 1;
        src_tag = 0; src_idx = 0;
        #12;
        chk("rst_weight_valid", 64'(bus.o_weight_valid), 64'd0);
        chk("rst_finish", 64'(o_load_w_finish), 64'd0);
        chk("rst_pe_valid", 64'(bus.o_pe_weight_valid), 64'd0);
        chk("rst_pe_last", 64'(bus.o_pe_weight_last), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_pe_weight", bus.o_pe_weight, 64'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("rst_checksum", 64'(o_checksum), 64'd0);
`endif
        s_rst_n = 1;
        repeat (2) @(posedge s_clk);

        // 64 words, everything ready: words 0..63, first valid at T+4, finish at T+70.
        start_pass(64, 32'd0);
        wait_fin("p64", 300, 0);
        chk_data("p64", 64, 32'd0);
        chk("p64_first_valid", 64'(first_valid - t0), 64'd4);
        chk("p64_fin_time", 64'(fin_cyc - t0), 64'd70);
        chk("p64_busy_after", 64'(o_busy), 64'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("p64_checksum", 64'(o_checksum), 64'd2016);
`endif

        // 40 words: chunks of 32 then 8, one WAIT cycle between; start while busy ignored.
        start_pass(40, 32'h11);
        repeat (8) @(posedge s_clk);
        #1 i_start = 1; i_total_words = 20'd5;
        @(posedge s_clk); #1 i_start = 0;
        wait_fin("p40", 300, 0);
        chk_data("p40", 40, 32'h11);
        chk("p40_chunk_gap", 64'(read_cyc.size() > 32 ? read_cyc[32] - read_cyc[31] : -1), 64'd2);
        chk("p40_in_chunk", 64'(read_cyc.size() > 1 ? read_cyc[1] - read_cyc[0] : -1), 64'd1);
        chk("p40_fin_time", 64'(fin_cyc - t0), 64'd46);

        // Ready low 20 cycles, then one ready sample: a full 32-word chunk only.
        bus.i_weight_ready = 0;
        start_pass(64, 32'h3);
        repeat (20) @(posedge s_clk);
        #1 chk("rdy_low_no_reads", 64'(n_reads), 64'd0);
        bus.i_weight_ready = 1;
        @(posedge s_clk); #1 bus.i_weight_ready = 0;
        repeat (50) @(posedge s_clk);
        #1 chk("rdy_one_chunk", 64'(n_reads), 64'd32);
        bus.i_weight_ready = 1;
        wait_fin("rdy", 300, 0);
        chk_data("rdy", 64, 32'h3);

        // Random PE backpressure over 96 words.
        start_pass(96, 32'h5);
        wait_fin("bp96", 2000, 1);
        chk_data("bp96", 96, 32'h5);
        chk("bp96_stall_stable", 64'(stall_err), 64'd0);
        chk("bp96_no_overflow", 64'(ovf), 64'd0);

        // Zero-length pass: no reads, finish at T+2.
        start_pass(0, 32'h0);
        wait_fin("zero", 20, 0);
        chk("zero_reads", 64'(n_reads), 64'd0);
        chk("zero_fin_time", 64'(fin_cyc - t0), 64'd2);
        chk("zero_fin_pulses", 64'(n_fin), 64'd1);

        // Reset at word 17 of a 64-word pass.
        start_pass(64, 32'h7);
        for (int i = 0; i < 200 && got.size() < 17; i++) @(posedge s_clk);
        #3 s_rst_n = 0;
        #1;
        chk("abort_weight_valid", 64'(bus.o_weight_valid), 64'd0);
        chk("abort_pe_valid", 64'(bus.o_pe_weight_valid), 64'd0);
        chk("abort_pe_weight", bus.o_pe_weight, 64'd0);
        chk("abort_pe_last", 64'(bus.o_pe_weight_last), 64'd0);
        chk("abort_busy", 64'(o_busy), 64'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("abort_checksum", 64'(o_checksum), 64'd0);
`endif
        repeat (3) @(posedge s_clk);
        #1 s_rst_n = 1;
        repeat (20) @(posedge s_clk);
        #1 chk("abort_no_finish", 64'(n_fin), 64'd0);
        start_pass(20, 32'h9);
        wait_fin("after", 200, 0);
        chk_data("after", 20, 32'h9);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("after_checksum", 64'(o_checksum), 64'(cks(32'h9, 20)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
